// File: rtl/dst_serializer.sv
// Captures the compressor result WIDTH bits a programmable number of cycles after a
// capture request, then streams it out LSB-first on a 1-bit valid/ready channel.
module dst_serializer #(
  parameter int unsigned WIDTH  = 25,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dst,
  input  logic             cap_req,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q,  bcnt_d;
  logic [SW-1:0]    scnt_q,  scnt_d;
  logic             done_q,  done_d;
  logic             ovr_q,   ovr_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (cap_req && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (cap_req) begin
          // With SETTLE=0 the WAIT branch is constant-false and folds away.
          if (SETTLE == 0) begin
            state_d = S_SEND;
            shreg_d = dst;
            bcnt_d  = '0;
          end else begin
            state_d = S_WAIT;
            scnt_d  = SW'(SETTLE - 1);
          end
        end
      end
      S_WAIT: begin
        if (scnt_q == '0) begin
          state_d = S_SEND;
          shreg_d = dst;
          bcnt_d  = '0;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end
      S_SEND: begin
        if (ser_ready) begin
          shreg_d = shreg_q >> 1;
          if (bcnt_q == BW'(WIDTH - 1)) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
            done_d  = 1'b1;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ser_valid = (state_q == S_SEND);
  assign ser_data  = ser_valid & shreg_q[0];
  assign ser_last  = ser_valid && (bcnt_q == BW'(WIDTH - 1));
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_dst_serializer.sv
// Randomized bench for dst_serializer: each frame's expected word is the dst value the
// bench held at the edge SETTLE cycles after the capture edge.
module tb_dst_serializer;
  localparam int unsigned WIDTH  = 25;
  localparam int unsigned SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] dst;
  logic             cap_req;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             busy;
  logic             done;
  logic             overrun;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          ovr_exp  = 1'b0;

  always #5 clk = ~clk;

  dst_serializer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dst       (dst),
    .cap_req   (cap_req),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic pick_ready(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return ((i % 4) == 0) || ((i % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Called just after a negedge with the DUT idle; returns at the negedge of the done cycle
  // (or, when rst_beat hits, at the first idle negedge after reset release).
  task automatic frame(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                       input int mode, input int ovr_beat, input int rst_beat);
    logic [WIDTH-1:0] got = '0;
    logic [WIDTH-1:0] exp;
    int   beat = 0;
    int   cyc  = 0;
    int   ridx = 0;
    bit   pend = 1'b0;
    bit   ovr_sent = 1'b0;
    logic pd = 1'b0;
    logic pl = 1'b0;

    check_eq("idle_valid", 32'(ser_valid), 32'd0);
    dst     = d0;
    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
    dst     = d1;
    exp     = d1;
    for (int c = 0; c < int'(SETTLE); c++) begin
      if (c > 0) @(negedge clk);
      check_eq("wait_busy", 32'(busy), 32'd1);
      check_eq("wait_valid", 32'(ser_valid), 32'd0);
    end

    while (beat < int'(WIDTH)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        check_eq("beat_timeout", 32'(beat), 32'(WIDTH));
        cap_req = 1'b0;
        return;
      end
      dst = WIDTH'($urandom);
      check_eq("send_valid", 32'(ser_valid), 32'd1);
      if (pend) begin
        check_eq("hold_data", 32'(ser_data), 32'(pd));
        check_eq("hold_last", 32'(ser_last), 32'(pl));
      end
      if (rst_beat == beat) begin
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(ser_valid), 32'd0);
        check_eq("arst_data", 32'(ser_data), 32'd0);
        check_eq("arst_last", 32'(ser_last), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_ovr", 32'(overrun), 32'd0);
        ovr_exp = 1'b0;
        cap_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_done", 32'(done), 32'd0);
        return;
      end
      ser_ready = pick_ready(mode, ridx);
      ridx++;
      if (ovr_beat == beat && !ovr_sent) begin
        cap_req  = 1'b1;
        ovr_sent = 1'b1;
        ovr_exp  = 1'b1;
      end else begin
        cap_req = 1'b0;
      end
      check_eq("last_flag", 32'(ser_last), 32'(beat == int'(WIDTH) - 1));
      if (ser_ready) begin
        got[beat] = ser_data;
        beat++;
        pend = 1'b0;
      end else begin
        pend = 1'b1;
        pd   = ser_data;
        pl   = ser_last;
      end
    end

    @(negedge clk);
    cap_req   = 1'b0;
    ser_ready = 1'($urandom_range(0, 1));
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("done_busy", 32'(busy), 32'd0);
    check_eq("done_valid", 32'(ser_valid), 32'd0);
    check_eq("word", 32'(got), 32'(exp));
    check_eq("overrun", 32'(overrun), 32'(ovr_exp));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check_eq("done_clear", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] a;
    rst_n     = 1'b0;
    cap_req   = 1'b0;
    dst       = '0;
    ser_ready = 1'b0;
    #12;
    check_eq("rst_valid", 32'(ser_valid), 32'd0);
    check_eq("rst_data", 32'(ser_data), 32'd0);
    check_eq("rst_last", 32'(ser_last), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    frame(25'h1555555, 25'h1555555, 0, -1, -1);
    idle_cycle();
    frame(25'h0000001, 25'h1000000, 0, -1, -1);
    idle_cycle();
    frame(25'h0ABCDEF, 25'h0ABCDEF, 1, -1, -1);
    idle_cycle();

    a = WIDTH'($urandom);
    frame(a, a, 2, 5, -1);
    idle_cycle();
    frame(WIDTH'($urandom), WIDTH'($urandom), 2, -1, -1);
    idle_cycle();

    frame(WIDTH'($urandom), WIDTH'($urandom), 0, -1, 12);
    check_eq("rst_ovr_clear", 32'(overrun), 32'd0);
    frame(25'h1FFFFFF, 25'h1FFFFFF, 0, -1, -1);
    idle_cycle();

    frame(WIDTH'($urandom), WIDTH'($urandom), 0, -1, -1);
    frame(WIDTH'($urandom), WIDTH'($urandom), 0, -1, -1);
    idle_cycle();

    for (int i = 0; i < 10; i++) begin
      frame(WIDTH'($urandom), WIDTH'($urandom), 2, -1, -1);
      idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
